// File: rtl/mem_bank_pipe_pkg.sv
// Shared types and helpers for the banked memory model.
// Word bytes are byte_t; byte 0 is the most significant.
package mem_pkg;

    typedef logic [7:0] byte_t;

    function automatic int addr_width(input int depth, input int nbytes);
        return $clog2(depth * nbytes);
    endfunction

endpackage

// File: rtl/mem_bank_pipe_if.sv
// Request/response bus of the memory model.
// master drives requests and consumes responses.
interface mem_bank_pipe_if
    import mem_pkg::*;
#(
    parameter int NUM_BYTES = 2,
    parameter int MEM_DEPTH = 4096
) ();
    localparam int ADDR_WIDTH = addr_width(MEM_DEPTH, NUM_BYTES);

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_rd;
    logic [0:NUM_BYTES-1]      req_we;
    logic [ADDR_WIDTH-1:0]     req_addr;
    byte_t [0:NUM_BYTES-1]     req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    byte_t [0:NUM_BYTES-1]     rsp_rdata;

    modport master (
        output req_valid, req_rd, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_rd, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_bank_pipe_fifo.sv
// Show-ahead synchronous FIFO, any depth >= 2.
// dout presents the head entry whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (pop)  rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem[rp];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/mem_bank_pipe.sv
// Byte-write SRAM model behind valid/ready ports; reads flow
// through a fixed-latency pipe into a credit-limited response FIFO.
module mem_bank_pipe
    import mem_pkg::*;
#(
    parameter int NUM_BYTES  = 2,
    parameter int MEM_DEPTH  = 4096,
    parameter int RD_LATENCY = 1
) (
    input logic            clk,
    input logic            rst,
    mem_bank_pipe_if.slave bus
);
    localparam int ADDR_WIDTH = addr_width(MEM_DEPTH, NUM_BYTES);
    localparam int RSP_DEPTH  = RD_LATENCY + 1;
    localparam int OFS        = $clog2(NUM_BYTES);
    localparam int IDX_W      = ADDR_WIDTH - OFS;
    localparam int CW         = $clog2(RSP_DEPTH + 1);
    localparam int WW         = 8 * NUM_BYTES;

    typedef byte_t [0:NUM_BYTES-1] word_t;

    word_t            ram [MEM_DEPTH];
    logic [IDX_W-1:0] idx;
    logic             acc;
    logic             rd_acc;
    logic             take;
    logic             push_v;
    word_t            rd_word;
    word_t            push_d;
    word_t            fifo_dout;
    word_t            last_q;
    logic [CW-1:0]    cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             rsp_v;

    assign idx           = bus.req_addr[ADDR_WIDTH-1:OFS];
    assign bus.req_ready = !rst && (cnt < CW'(RSP_DEPTH));
    assign acc           = bus.req_valid && bus.req_ready;
    assign rd_acc        = acc && bus.req_rd;
    // Combinational sample before the write edge gives read-first.
    assign rd_word       = ram[idx];

    always_ff @(posedge clk) begin
        if (acc) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.req_we[i]) ram[idx][i] <= bus.req_wdata[i];
            end
        end
    end

    if (RD_LATENCY == 1) begin : g_l1
        assign push_v = rd_acc;
        assign push_d = rd_word;
    end else begin : g_pipe
        logic [RD_LATENCY-2:0] sv;
        word_t                 sd [RD_LATENCY-1];

        always_ff @(posedge clk) begin
            if (rst) sv <= '0;
            else     sv <= {sv, rd_acc};
            sd[0] <= rd_word;
            for (int k = 1; k < RD_LATENCY - 1; k++) sd[k] <= sd[k-1];
        end

        assign push_v = sv[RD_LATENCY-2];
        assign push_d = sd[RD_LATENCY-2];
    end

    if (OFS > 0) begin : g_lo
        logic unused_lo;
        assign unused_lo = ^bus.req_addr[OFS-1:0];
    end

    sync_fifo #(
        .WIDTH (WW),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_v),
        .din   (push_d),
        .pop   (take),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rsp_v         = !rst && !fifo_empty;
    assign take          = rsp_v && bus.rsp_ready;
    assign bus.rsp_valid = rsp_v;
    assign bus.rsp_rdata = rst ? '0 : (rsp_v ? fifo_dout : last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            last_q <= '0;
        end else begin
            cnt <= cnt + CW'(rd_acc) - CW'(take);
            if (take) last_q <= fifo_dout;
        end
    end

    // Credits bound in-flight reads, so the FIFO can never overflow.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push_v && fifo_full));
    end

endmodule
